// File: rtl/vc_input_buffer.sv
// Four-VC router input buffer: one circular FIFO per virtual channel.
// Ports: clk, reset_n, in_valid/in_vc/in_data/in_ready (push side),
// request (per-VC non-empty), grant (3-bit code, 0..3 valid),
// out_ready/out_valid/out_data/out_vc (pop side), ovf_err (sticky per VC).
module vc_input_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [1:0]        in_vc,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [3:0]        request,
    input  logic [2:0]        grant,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_vc,
    output logic [3:0]        ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem  [4][DEPTH];
    logic [AW-1:0]     wptr [4];
    logic [AW-1:0]     rptr [4];
    logic [CW-1:0]     cnt  [4];

    logic       gnt_ok;
    logic [1:0] gnt_vc;
    logic       push;
    logic       pop;
    logic [3:0] push_v;
    logic [3:0] pop_v;

    // Grant codes 4..7 mean "no grant".
    assign gnt_ok = (grant[2] == 1'b0);
    assign gnt_vc = grant[1:0];

    assign in_ready  = (cnt[in_vc] != FULL);
    assign out_valid = gnt_ok && (cnt[gnt_vc] != '0);
    assign out_vc    = gnt_ok ? gnt_vc : 2'd0;
    // Reads only registered state, so a same-cycle push never bypasses.
    assign out_data  = out_valid ? mem[gnt_vc][rptr[gnt_vc]] : '0;

    assign push   = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    assign push_v = push ? (4'b0001 << in_vc) : 4'b0000;
    assign pop_v  = pop ? (4'b0001 << gnt_vc) : 4'b0000;

    always_comb begin
        request = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            request[i] = (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            ovf_err <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push_v[i]) begin
                    wptr[i] <= wptr[i] + AW'(1);
                end
                if (pop_v[i]) begin
                    rptr[i] <= rptr[i] + AW'(1);
                end
                // Push and pop on the same VC cancel in the count.
                if (push_v[i] && !pop_v[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (!push_v[i] && pop_v[i]) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
            if (in_valid && !in_ready) begin
                ovf_err[in_vc] <= 1'b1;
            end
        end
    end

    // Storage is not reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[in_vc][wptr[in_vc]] <= in_data;
        end
    end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Randomized and directed bench for vc_input_buffer.
// A queue-per-VC model is checked every cycle by a monitor process.
module tb_vc_input_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic [1:0]        in_vc;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [3:0]        request;
    logic [2:0]        grant;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_vc;
    logic [3:0]        ovf_err;

    vc_input_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_vc    (in_vc),
        .in_data  (in_data),
        .in_ready (in_ready),
        .request  (request),
        .grant    (grant),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_vc   (out_vc),
        .ovf_err  (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    logic [DATA_W-1:0] q [4][$];
    logic [3:0]        m_ovf;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs with the model, then commit this cycle.
    always @(negedge clk) begin
        if (!done) begin
            if (!reset_n) begin
                for (int i = 0; i < 4; i++) q[i].delete();
                m_ovf = 4'b0000;
                chk("rst_request", 64'(request), 64'(4'b0000));
                chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
                chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
                chk("rst_out_data", 64'(out_data), 64'(0));
                chk("rst_ovf_err", 64'(ovf_err), 64'(4'b0000));
            end else begin
                logic       e_rdy;
                logic       e_ov;
                logic [3:0] e_req;
                logic [1:0] g;
                logic       gv;
                e_rdy = (q[in_vc].size() != DEPTH);
                for (int i = 0; i < 4; i++) e_req[i] = (q[i].size() != 0);
                gv   = (grant < 3'd4);
                g    = grant[1:0];
                e_ov = gv && (q[g].size() != 0);
                chk("in_ready", 64'(in_ready), 64'(e_rdy));
                chk("request", 64'(request), 64'(e_req));
                chk("out_valid", 64'(out_valid), 64'(e_ov));
                chk("out_vc", 64'(out_vc), 64'(gv ? g : 2'd0));
                chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
                if (e_ov) chk("out_data", 64'(out_data), 64'(q[g][0]));
                else chk("out_data_zero", 64'(out_data), 64'(0));
                if (e_ov && out_ready) void'(q[g].pop_front());
                if (in_valid) begin
                    if (e_rdy) q[in_vc].push_back(in_data);
                    else m_ovf[in_vc] = 1'b1;
                end
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] vc,
                        input logic [DATA_W-1:0] d, input logic [2:0] g,
                        input logic ordy);
        in_valid  = v;
        in_vc     = vc;
        in_data   = d;
        grant     = g;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_vc     = 2'd0;
        in_data   = '0;
        grant     = 3'b111;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single push to VC2, no grant.
        step(1, 2, 32'hA1, 3'b111, 0);
        step(0, 0, 0, 3'b111, 0);

        // Fill VC1 then overflow it.
        for (int k = 0; k < 4; k++) step(1, 1, 32'h10 + k, 3'b111, 0);
        step(1, 1, 32'hEE, 3'b111, 0);
        step(0, 1, 0, 3'b111, 0);

        // Two flits drained back to back from VC0.
        do_reset();
        step(1, 0, 32'h55, 3'b111, 0);
        step(1, 0, 32'h66, 3'b111, 0);
        step(0, 0, 0, 3'b000, 1);
        step(0, 0, 0, 3'b000, 1);
        step(0, 0, 0, 3'b000, 1);

        // Push into full VC3 while popping it.
        for (int k = 0; k < 4; k++) step(1, 3, 32'h30 + k, 3'b111, 0);
        step(1, 3, 32'h99, 3'b011, 1);
        step(0, 3, 0, 3'b011, 0);

        // Same-VC push/pop with pointer wrap on VC1.
        do_reset();
        step(1, 1, 32'h20, 3'b111, 0);
        step(1, 1, 32'h21, 3'b111, 0);
        for (int k = 0; k < 6; k++) step(1, 1, 32'h77 + k, 3'b001, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 3'b001, 1);

        // Grant moves while stalled; VC0 head must be retained.
        do_reset();
        step(1, 0, 32'hC0, 3'b111, 0);
        step(1, 2, 32'hC2, 3'b111, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 3'b000, 0);
        step(0, 0, 0, 3'b010, 0);
        step(0, 0, 0, 3'b000, 1);
        step(0, 0, 0, 3'b010, 1);

        // Grant at an empty VC and invalid grant codes.
        step(0, 0, 0, 3'b001, 1);
        step(0, 0, 0, 3'b101, 1);

        // Random traffic with occasional mid-run resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            step(($urandom_range(0, 9) < 6),
                 2'($urandom_range(0, 3)),
                 $urandom,
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1));
        end

        @(posedge clk);
        #1;
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
